// File: rtl/gabor_result_writer.sv
// Gabor result writer: accumulates the nine 3x3 kernel taps of each center
// pixel, scales and clamps the sum to a byte, stores it in a frame buffer
// and, once the last center of the frame is committed, streams the whole
// buffer out in address order over a valid/ready interface.
module gabor_result_writer #(
  parameter int SHIFT = 7,
  parameter int NPIX  = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tap_valid,
  input  logic [3:0] tap_idx,
  input  logic [7:0] center_idx,
  input  logic [7:0] pixel_in,
  input  logic [7:0] coeff_in,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       res_wr_en,
  output logic [7:0] res_addr,
  output logic       busy,
  output logic       seq_err,
  output logic       done
);

  localparam int AW    = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int PTR_W = $clog2(NPIX + 1);

  typedef enum logic [1:0] {
    S_ACC,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic signed [19:0] acc_q, acc_d;
  logic [3:0]         exp_tap_q, exp_tap_d;
  logic               seq_err_q, seq_err_d;
  logic               res_wr_en_q, res_wr_en_d;
  logic [7:0]         res_addr_q, res_addr_d;
  logic [7:0]         wr_data_q, wr_data_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic               out_valid_q, out_valid_d;
  logic [7:0]         out_data_q, out_data_d;
  logic               done_q, done_d;

  logic [7:0]         mem [NPIX];
  logic [7:0]         rd_data;

  logic [3:0]         tap_row, tap_col;
  logic signed [6:0]  row, col;
  logic               outside;
  logic signed [16:0] product;
  logic signed [19:0] acc_next;
  logic signed [19:0] shifted;
  logic [7:0]         sat;

  // Tap datapath: border masking, signed product, running sum, scaled and clamped result.
  always_comb begin
    tap_row  = tap_idx / 4'd3;
    tap_col  = tap_idx % 4'd3;
    row      = $signed({3'b000, center_idx[7:4]}) + $signed({3'b000, tap_row}) - 7'sd1;
    col      = $signed({3'b000, center_idx[3:0]}) + $signed({3'b000, tap_col}) - 7'sd1;
    outside  = (row < 7'sd0) || (row > 7'sd15) || (col < 7'sd0) || (col > 7'sd15);
    product  = outside ? 17'sd0
                       : $signed({9'b0, pixel_in}) * $signed({{9{coeff_in[7]}}, coeff_in});
    acc_next = (tap_idx == 4'd0) ? {{3{product[16]}}, product}
                                 : acc_q + {{3{product[16]}}, product};
    shifted  = acc_next >>> SHIFT;
    if (shifted < 20'sd0) begin
      sat = 8'd0;
    end else if (shifted > 20'sd255) begin
      sat = 8'd255;
    end else begin
      sat = shifted[7:0];
    end
  end

  assign rd_data = mem[rd_ptr_q[AW-1:0]];

  // Next-state and output logic for accumulate, drain and done phases.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned (no latches).
    state_d     = state_q;
    acc_d       = acc_q;
    exp_tap_d   = exp_tap_q;
    seq_err_d   = seq_err_q;
    res_wr_en_d = 1'b0;
    res_addr_d  = res_addr_q;
    wr_data_d   = wr_data_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    done_d      = done_q;

    case (state_q)
      S_ACC: begin
        if (tap_valid) begin
          acc_d = acc_next;
          if (tap_idx != exp_tap_q) begin
            seq_err_d = 1'b1;
          end
          exp_tap_d = (tap_idx == 4'd8) ? 4'd0 : tap_idx + 4'd1;
          if (tap_idx == 4'd8) begin
            res_wr_en_d = 1'b1;
            res_addr_d  = center_idx;
            wr_data_d   = sat;
            if (center_idx == 8'(NPIX - 1)) begin
              state_d = S_DRAIN;
            end
          end
        end
      end

      S_DRAIN: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
        end
        // Hold off the first fetch while the final result is still being written.
        if (!res_wr_en_q && (rd_ptr_q != PTR_W'(NPIX)) && (!out_valid_q || out_ready)) begin
          out_data_d  = rd_data;
          out_valid_d = 1'b1;
          rd_ptr_d    = rd_ptr_q + PTR_W'(1);
        end else if (out_valid_q && out_ready && (rd_ptr_q == PTR_W'(NPIX))) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end

      S_DONE: begin
      end

      default: begin
        state_d = S_ACC;
      end
    endcase
  end

  // Control and pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q     <= S_ACC;
      acc_q       <= '0;
      exp_tap_q   <= '0;
      seq_err_q   <= 1'b0;
      res_wr_en_q <= 1'b0;
      res_addr_q  <= '0;
      wr_data_q   <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      exp_tap_q   <= exp_tap_d;
      seq_err_q   <= seq_err_d;
      res_wr_en_q <= res_wr_en_d;
      res_addr_q  <= res_addr_d;
      wr_data_q   <= wr_data_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
    end
  end

  // Result buffer write, one cycle after the tap-8 cycle.
  always_ff @(posedge clk) begin
    // NOTE: the buffer array is deliberately not reset; only control state needs a known value.
    if (res_wr_en_q) begin
      mem[res_addr_q[AW-1:0]] <= wr_data_q;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign res_wr_en = res_wr_en_q;
  assign res_addr  = res_addr_q;
  assign seq_err   = seq_err_q;
  assign done      = done_q;
  assign busy      = (state_q != S_DONE);

endmodule

// File: tb/tb_gabor_result_writer.sv
// Self-checking bench for gabor_result_writer: table vectors for known
// centers, randomized frames against a per-center arithmetic model, and
// hand-written sequences for tap-order errors and mid-frame reset.
module tb_gabor_result_writer;

  localparam int SHIFT = 7;
  localparam int NPIX  = 256;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tap_valid = 1'b0;
  logic [3:0] tap_idx = '0;
  logic [7:0] center_idx = '0;
  logic [7:0] pixel_in = '0;
  logic [7:0] coeff_in = '0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [7:0] out_data;
  logic       res_wr_en;
  logic [7:0] res_addr;
  logic       busy;
  logic       seq_err;
  logic       done;

  gabor_result_writer #(.SHIFT(SHIFT), .NPIX(NPIX)) dut (
    .clk       (clk),
    .reset     (reset),
    .tap_valid (tap_valid),
    .tap_idx   (tap_idx),
    .center_idx(center_idx),
    .pixel_in  (pixel_in),
    .coeff_in  (coeff_in),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .res_wr_en (res_wr_en),
    .res_addr  (res_addr),
    .busy      (busy),
    .seq_err   (seq_err),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int center;
    int pix;
    int coef;
    int exp_res;
  } vec_t;

  typedef struct {
    int cyc;
    int addr;
  } cmt_t;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   entry_cyc = -1;
  cmt_t cmt_q[$];
  cmt_t mon_e;
  int   exp_buf[NPIX];
  int   got_buf[NPIX];
  int   pix_a[9];
  int   coef_a[9];
  vec_t tbl[9];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, got, got, exp, exp, cyc);
    end
  endtask

  // Reference: sum in-image taps with plain integer math, floor-scale, clamp.
  function automatic int model_result(input int center);
    int acc = 0;
    for (int t = 0; t < 9; t++) begin
      int r = center / 16 + t / 3 - 1;
      int c = center % 16 + t % 3 - 1;
      if (r >= 0 && r <= 15 && c >= 0 && c <= 15) acc += pix_a[t] * coef_a[t];
    end
    acc = acc >>> SHIFT;
    if (acc < 0) return 0;
    if (acc > 255) return 255;
    return acc;
  endfunction

  // Commit monitor: every res_wr_en pulse must match an expected (cycle, address).
  always @(negedge clk) begin
    if (!reset) begin
      if (res_wr_en) begin
        if (cmt_q.size() == 0) begin
          check("unexpected_commit", {31'b0, res_wr_en}, 0);
        end else begin
          mon_e = cmt_q.pop_front();
          check("commit_cycle", cyc, mon_e.cyc);
          check("res_addr", {24'b0, res_addr}, mon_e.addr);
          if (res_addr == 8'(NPIX - 1)) entry_cyc = cyc;
        end
      end else if (cmt_q.size() != 0 && cmt_q[0].cyc <= cyc) begin
        check("missing_commit", {31'b0, res_wr_en}, 1);
        void'(cmt_q.pop_front());
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    tap_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    cmt_q.delete();
    entry_cyc = -1;
    @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid}, 0);
    check("rst_out_data", {24'b0, out_data}, 0);
    check("rst_res_wr_en", {31'b0, res_wr_en}, 0);
    check("rst_res_addr", {24'b0, res_addr}, 0);
    check("rst_seq_err", {31'b0, seq_err}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_busy", {31'b0, busy}, 1);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    reset = 1'b0;
    tap_valid = 1'b0;
  endtask

  task automatic send_tap(input int center, input int t);
    cmt_t e;
    @(posedge clk); #1;
    reset = 1'b0;
    tap_valid = 1'b1;
    tap_idx = 4'(t);
    center_idx = 8'(center);
    pixel_in = 8'(pix_a[t]);
    coeff_in = 8'(coef_a[t]);
    if (t == 8) begin
      e.cyc = cyc + 1;
      e.addr = center;
      cmt_q.push_back(e);
    end
  endtask

  task automatic send_center(input int center, input bit gaps);
    exp_buf[center] = model_result(center);
    for (int t = 0; t < 9; t++) begin
      if (gaps && $urandom_range(0, 7) == 0) idle();
      send_tap(center, t);
    end
  endtask

  task automatic randomize_taps();
    for (int t = 0; t < 9; t++) begin
      pix_a[t] = int'($urandom_range(0, 255));
      coef_a[t] = int'($urandom_range(0, 255)) - 128;
    end
  endtask

  // Drain the frame; junk taps are driven throughout and must be ignored.
  task automatic drain(input bit pattern);
    int n = 0;
    int budget = 0;
    int first_valid = -1;
    bit held = 1'b0;
    int held_data = 0;
    while (n < NPIX && budget < 4 * NPIX + 20) begin
      @(posedge clk); #1;
      reset = 1'b0;
      tap_valid = 1'b1;
      tap_idx = 4'd8;
      center_idx = 8'($urandom_range(0, 255));
      pixel_in = 8'($urandom_range(0, 255));
      coeff_in = 8'($urandom_range(0, 255));
      out_ready = pattern ? (budget % 3 == 0) : ($urandom_range(0, 1) == 1);
      @(negedge clk);
      budget++;
      if (held) begin
        check("hold_valid", {31'b0, out_valid}, 1);
        check("hold_data", {24'b0, out_data}, held_data);
      end
      held = 1'b0;
      if (out_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (out_ready) begin
          check("drain_data", {24'b0, out_data}, exp_buf[n]);
          got_buf[n] = int'(out_data);
          n++;
        end else begin
          held = 1'b1;
          held_data = int'(out_data);
        end
      end
    end
    check("drain_count", n, NPIX);
    check("valid_latency_ok", {31'b0, (first_valid >= 0 && entry_cyc >= 0 &&
                                       first_valid - entry_cyc <= 2)}, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("valid_drop", {31'b0, out_valid}, 0);
    check("done_set", {31'b0, done}, 1);
    check("busy_clear", {31'b0, busy}, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("done_sticky", {31'b0, done}, 1);
    check("valid_idle", {31'b0, out_valid}, 0);
    tap_valid = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hit;
    tbl[0] = '{17, 100, 2, 14};
    tbl[1] = '{0, 200, 127, 255};
    tbl[2] = '{5, 255, -128, 0};
    tbl[3] = '{240, 100, 50, 156};
    tbl[4] = '{34, 128, 1, 9};
    tbl[5] = '{15, 64, 64, 128};
    tbl[6] = '{51, 55, 66, 255};
    tbl[7] = '{52, 57, 64, 255};
    tbl[8] = '{53, 1, -1, 0};

    // Frame A: table centers back to back, other centers random with gaps.
    do_reset();
    for (int c = 0; c < NPIX; c++) begin
      hit = -1;
      for (int i = 0; i < 9; i++) if (tbl[i].center == c) hit = i;
      if (hit >= 0) begin
        for (int t = 0; t < 9; t++) begin
          pix_a[t] = tbl[hit].pix;
          coef_a[t] = tbl[hit].coef;
        end
        send_center(c, 1'b0);
      end else begin
        randomize_taps();
        send_center(c, 1'b1);
      end
    end
    drain(1'b0);
    check("frame_a_seq_err", {31'b0, seq_err}, 0);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("table_c%0d", tbl[i].center), got_buf[tbl[i].center], tbl[i].exp_res);
    end

    // Frame B: result equals center index, throttled drain 1,0,0,...
    do_reset();
    for (int c = 0; c < NPIX; c++) begin
      randomize_taps();
      for (int t = 0; t < 9; t++) coef_a[t] = 0;
      pix_a[4] = c;
      coef_a[4] = 64;
      if (c % 16 != 15) begin
        pix_a[5] = c;
        coef_a[5] = 64;
      end else begin
        pix_a[3] = c;
        coef_a[3] = 64;
      end
      send_center(c, 1'b0);
    end
    drain(1'b1);
    for (int c = 0; c < NPIX; c++) check("frame_b_byte", got_buf[c], c);

    // Tap-order error: 0,1,3 sets the sticky flag.
    do_reset();
    randomize_taps();
    send_tap(0, 0);
    send_tap(0, 1);
    idle();
    @(negedge clk);
    check("seq_ok_after_tap1", {31'b0, seq_err}, 0);
    send_tap(0, 3);
    idle();
    @(negedge clk);
    check("seq_err_after_tap3", {31'b0, seq_err}, 1);
    for (int t = 4; t < 9; t++) send_tap(0, t);
    randomize_taps();
    send_center(1, 1'b1);
    idle();
    repeat (3) @(negedge clk);
    check("seq_err_sticky", {31'b0, seq_err}, 1);

    // Reset during center 100 tap 4, then a fresh random frame.
    do_reset();
    randomize_taps();
    send_center(99, 1'b0);
    randomize_taps();
    for (int t = 0; t < 4; t++) send_tap(100, t);
    @(posedge clk); #1;
    tap_valid = 1'b1;
    tap_idx = 4'd4;
    center_idx = 8'd100;
    reset = 1'b1;
    do_reset();
    for (int c = 0; c < NPIX; c++) begin
      randomize_taps();
      send_center(c, 1'b1);
    end
    drain(1'b0);
    check("frame_c_seq_err", {31'b0, seq_err}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gabor_result_writer.md
GABOR_RESULT_WRITER -- requirements
Module: gabor_result_writer

Interface
REQ-001 The block SHALL have parameter SHIFT, default 7, giving the arithmetic right-shift applied to the 9-tap sum.
REQ-002 The block SHALL have parameter NPIX, default 256, giving the number of centers per frame (16x16 image).
REQ-003 The block SHALL have a single clock domain; reset SHALL be synchronous and active-high.
REQ-004 clk  input  1  sole clock, rising-edge.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 tap_valid  input  1  tap sample present this cycle.
REQ-007 tap_idx  input  4  kernel tap index 0..8 (row-major 3x3).
REQ-008 center_idx  input  8  center pixel index 0..255 for the current tap.
REQ-009 pixel_in  input  8  unsigned image sample for the tap.
REQ-010 coeff_in  input  8  signed two's-complement Gabor coefficient for the tap.
REQ-011 out_ready  input  1  downstream accepts out_data.
REQ-012 out_valid  output  1  out_data holds a valid result byte.
REQ-013 out_data  output  8  unsigned filtered pixel.
REQ-014 res_wr_en  output  1  one-cycle pulse when a result is committed.
REQ-015 res_addr  output  8  buffer address of the committed result (equals center_idx).
REQ-016 busy  output  1  high in S_ACC and S_DRAIN.
REQ-017 seq_err  output  1  sticky tap-sequence error flag.
REQ-018 done  output  1  frame fully drained.

Function
REQ-019 The FSM SHALL have states S_ACC, S_DRAIN and S_DONE; reset SHALL enter S_ACC.
REQ-020 In S_ACC, each tap_valid cycle SHALL form product = pixel_in (zero-extended) x coeff_in (signed), 17-bit signed.
REQ-021 The product SHALL be forced to 0 when the tap falls outside the image: row = center_idx/16 + tap_idx/3 - 1 and col = center_idx%16 + tap_idx%3 - 1, with row or col outside 0..15.
REQ-022 The accumulator SHALL be 20-bit signed; a tap with tap_idx=0 SHALL load it with the product, and taps 1..8 SHALL add the product.
REQ-023 An expected-tap counter SHALL track the next tap index; a tap_idx that differs from it SHALL set seq_err and resynchronise the counter to tap_idx+1; seq_err SHALL be cleared only by reset.
REQ-024 On an accepted tap_idx=8, result = acc_final >>> SHIFT, saturated to 0..255 (negative -> 0, >255 -> 255).
REQ-025 The result SHALL be written to an internal NPIX x 8 buffer at center_idx, with res_wr_en=1 and res_addr=center_idx exactly one cycle after the tap-8 cycle.
REQ-026 Back-to-back taps, including tap 0 of the next center in the cycle after tap 8, SHALL be accepted without stall.
REQ-027 A commit for center_idx=NPIX-1 SHALL move the FSM to S_DRAIN in the same cycle that res_wr_en is asserted.
REQ-028 tap_valid SHALL be ignored in S_DRAIN and S_DONE.
REQ-029 In S_DRAIN, the buffer SHALL be streamed in address order 0..NPIX-1; a transfer occurs on out_valid && out_ready.
REQ-030 out_valid SHALL assert no more than 2 cycles after S_DRAIN entry; out_data SHALL stay stable while out_valid && !out_ready.
REQ-031 With out_ready held high, the block SHALL sustain one transfer per cycle.
REQ-032 After transfer NPIX-1, out_valid SHALL drop in the next cycle and the FSM SHALL enter S_DONE; done SHALL then stay 1 until reset.
REQ-033 busy SHALL equal (state != S_DONE).

Reset
REQ-034 Reset SHALL set out_valid=0, out_data=0, res_wr_en=0, res_addr=0, seq_err=0, done=0, accumulator=0, expected tap=0, read pointer=0 and state=S_ACC.
REQ-035 Reset asserted mid-accumulation or mid-drain SHALL abandon the frame; buffer contents need not be cleared.
REQ-036 The first tap SHALL be accepted in the cycle after reset deasserts.

Verification
REQ-037 Center 17, all pixels 100, all coeffs 2, taps 0..8 -> acc=1800, out 1800>>>7=14, res_addr=17, res_wr_en one cycle after tap 8.
REQ-038 Center 0, all pixels 200, all coeffs 127 -> only taps 4, 5, 7, 8 count; acc=101600, result saturates to 255.
REQ-039 Center 5, all coeffs -128, pixels 255 -> negative sum, result 0.
REQ-040 Taps 0, 1, 3 for one center -> seq_err=1 after the tap-3 cycle and stays set through the remaining frame.
REQ-041 Full frame with result = center_idx%256, then out_ready toggled 1,0,0,1... -> 256 bytes 0..255 in order, no drop or duplicate, done=1 after the last.
REQ-042 Reset asserted at center 100, tap 4, then a fresh frame -> correct outputs; no res_wr_en for the abandoned center.
